// File: rtl/sample_buf_pkg.sv
// Shared definitions for the sample capture buffers and their read-side streamer.
package sample_buf_pkg;

    parameter int NUMBER_OF_CHANNELS  = 7;
    parameter int NUMBER_OF_BITS      = 8;
    parameter int SAMPLES_BUFFER_SIZE = 10;
    parameter int BUFFER_SIZE         = NUMBER_OF_BITS * SAMPLES_BUFFER_SIZE;

    parameter logic [3:0] HEADER_PREFIX = 4'hA;

    typedef enum logic [1:0] {IDLE, HEADER, DATA} rd_state_t;

endpackage

// File: rtl/sample_buffer_reader.sv
// Snapshots one or all capture-buffer channel windows and streams them
// byte-serially (header byte, then samples oldest first) over valid/ready.
module sample_buffer_reader #(
    parameter int NUMBER_OF_CHANNELS  = sample_buf_pkg::NUMBER_OF_CHANNELS,
    parameter int NUMBER_OF_BITS      = sample_buf_pkg::NUMBER_OF_BITS,
    parameter int SAMPLES_BUFFER_SIZE = sample_buf_pkg::SAMPLES_BUFFER_SIZE
) (
    input  logic                                                       clk,
    input  logic                                                       rst_n,
    input  logic                                                       ena,
    input  logic [NUMBER_OF_CHANNELS*NUMBER_OF_BITS*SAMPLES_BUFFER_SIZE-1:0] buf_in,
    input  logic                                                       start,
    input  logic [3:0]                                                 ch_sel,
    input  logic                                                       all_ch,
    output logic [7:0]                                                 out_data,
    output logic                                                       out_valid,
    input  logic                                                       out_ready,
    output logic                                                       out_last,
    output logic                                                       busy,
    output logic                                                       sel_err
);
    import sample_buf_pkg::*;

    localparam int BUF_W = NUMBER_OF_BITS * SAMPLES_BUFFER_SIZE;
    localparam int SIW   = (SAMPLES_BUFFER_SIZE > 1) ? $clog2(SAMPLES_BUFFER_SIZE) : 1;
    localparam logic [SIW-1:0] LAST_SAMPLE = SIW'(SAMPLES_BUFFER_SIZE - 1);
    localparam logic [3:0]     LAST_CH     = 4'(NUMBER_OF_CHANNELS - 1);

    rd_state_t                                            state;
    logic [3:0]                                           ch_idx;
    logic [SIW-1:0]                                       sample_idx;
    logic                                                 mode_all;
    logic [SAMPLES_BUFFER_SIZE-1:0][NUMBER_OF_BITS-1:0]   snapshot;

    logic [3:0]                start_ch;
    logic [3:0]                sel_ch;
    logic [BUF_W-1:0]          sel_slice;
    logic [SIW-1:0]            nxt_idx;
    logic [NUMBER_OF_BITS-1:0] nxt_byte;
    logic                      sel_bad;
    logic                      final_ch;
    logic                      xfer;

    assign start_ch = all_ch ? 4'd0 : ch_sel;
    // In IDLE the slice mux serves the start request; otherwise it looks ahead to the next channel.
    assign sel_ch   = (state == IDLE) ? start_ch : ch_idx + 4'd1;
    assign sel_bad  = !all_ch && ({1'b0, ch_sel} >= 5'(NUMBER_OF_CHANNELS));
    assign final_ch = !mode_all || (ch_idx == LAST_CH);
    assign nxt_idx  = (state == HEADER) ? '0 : sample_idx + 1'b1;
    assign xfer     = out_valid && out_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        sel_slice = '0;
        for (int c = 0; c < NUMBER_OF_CHANNELS; c++)
            if (sel_ch == 4'(c)) sel_slice = buf_in[c*BUF_W +: BUF_W];
    end

    always_comb begin
        nxt_byte = '0;
        for (int k = 0; k < SAMPLES_BUFFER_SIZE; k++)
            if (nxt_idx == SIW'(k)) nxt_byte = snapshot[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch_idx     <= '0;
            sample_idx <= '0;
            mode_all   <= 1'b0;
            snapshot   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            sel_err    <= 1'b0;
        end else if (ena) begin
            sel_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (sel_bad) begin
                            sel_err <= 1'b1;
                        end else begin
                            ch_idx    <= start_ch;
                            mode_all  <= all_ch;
                            snapshot  <= sel_slice;
                            out_data  <= {HEADER_PREFIX, start_ch};
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                            state     <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        sample_idx <= '0;
                        out_data   <= nxt_byte;
                        out_last   <= final_ch && (LAST_SAMPLE == '0);
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (sample_idx != LAST_SAMPLE) begin
                            sample_idx <= nxt_idx;
                            out_data   <= nxt_byte;
                            out_last   <= final_ch && (nxt_idx == LAST_SAMPLE);
                        end else if (!final_ch) begin
                            ch_idx   <= sel_ch;
                            snapshot <= sel_slice;
                            out_data <= {HEADER_PREFIX, sel_ch};
                            out_last <= 1'b0;
                            state    <= HEADER;
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
